assertion_gate_seq: RTL and testbench



---
 rtl/assertion_gate_seq.sv | 70 +++++++
 tb/tb_assertion_gate_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/assertion_gate_seq.sv
// assertion_gate_seq: registered gate that blanks in while a control bit asserts, plus a hold-off window
// Ports: clk; rst_n async active-low; in data (WIDTH); clr_i clears trip status;
//        out gated data; blocked = not passing; tripped sticky; trip_count saturating
module assertion_gate_seq #(
  parameter int WIDTH       = 4,
  parameter int CTRL_BIT    = 0,
  parameter int CTRL_POL    = 1,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             clr_i,
  output logic [WIDTH-1:0] out,
  output logic             blocked,
  output logic             tripped,
  output logic [CNT_W-1:0] trip_count
);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [1:0] PASS = 2'd0, BLOCK = 2'd1, HOLDOFF = 2'd2;
  if (WIDTH < 1 || CTRL_BIT >= WIDTH) begin : g_bad
    $error("assertion_gate_seq: CTRL_BIT must be < WIDTH and WIDTH >= 1");
  end
  logic [1:0]    state, nstate;
  logic [HW-1:0] cnt, ncnt;
  logic          cond, trip, retrig;
  assign cond = in[CTRL_BIT] == 1'(CTRL_POL);
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    trip   = 1'b0;
    retrig = 1'b0;
    case (state)
      PASS: begin
        nstate = cond ? BLOCK : PASS;
        trip   = cond;
      end
      BLOCK: begin
        nstate = cond ? BLOCK : (HOLD_CYCLES > 0) ? HOLDOFF : PASS;
        ncnt   = (!cond && HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : cnt;
      end
      HOLDOFF: begin
        nstate = cond ? BLOCK : (cnt == '0) ? PASS : HOLDOFF;
        ncnt   = (!cond && cnt != '0) ? cnt - 1'b1 : cnt;
        retrig = cond;
      end
      default: nstate = PASS;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PASS;
      cnt        <= '0;
      out        <= '0;
      blocked    <= 1'b0;
      tripped    <= 1'b0;
      trip_count <= '0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      out        <= (nstate == PASS) ? in : '0;
      blocked    <= nstate != PASS;
      tripped    <= (trip || retrig) ? 1'b1 : clr_i ? 1'b0 : tripped;
      // a new trip on the same edge as a clear restarts the count at one
      trip_count <= trip ? (clr_i ? CNT_W'(1) : (&trip_count ? trip_count : trip_count + 1'b1))
                         : clr_i ? '0 : trip_count;
    end
  end
endmodule

// File: tb/tb_assertion_gate_seq.sv
// tb_assertion_gate_seq: directed self-checking bench for assertion_gate_seq and three variants
module tb_assertion_gate_seq;
  logic       clk = 0, rst_n = 0, clr = 0;
  logic [3:0] in = 0;
  logic [3:0] out, out_c, out_h, out_p;
  logic       blk, blk_c, blk_h, blk_p, trp, trp_c, trp_h, trp_p;
  logic [7:0] cnt, cnt_h, cnt_p;
  logic [1:0] cnt_c;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  assertion_gate_seq dut (.clk(clk), .rst_n(rst_n), .in(in), .clr_i(clr), .out(out), .blocked(blk), .tripped(trp), .trip_count(cnt));
  assertion_gate_seq #(.CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .in(in), .clr_i(clr), .out(out_c), .blocked(blk_c), .tripped(trp_c), .trip_count(cnt_c));
  assertion_gate_seq #(.HOLD_CYCLES(0)) dut_h (.clk(clk), .rst_n(rst_n), .in(in), .clr_i(clr), .out(out_h), .blocked(blk_h), .tripped(trp_h), .trip_count(cnt_h));
  assertion_gate_seq #(.CTRL_POL(0)) dut_p (.clk(clk), .rst_n(rst_n), .in(in), .clr_i(clr), .out(out_p), .blocked(blk_p), .tripped(trp_p), .trip_count(cnt_p));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset();
    rst_n = 0;
    clr = 0;
    in = 0;
    step();
    rst_n = 1;
  endtask
  task automatic do_trip();
    in = 4'b1011;
    step();
    in = 4'b1010;
    repeat (4) step();
  endtask
  task automatic test_reset();
    reset();
    in = 4'b1011;
    step();
    in = 4'b1010;
    step();
    step();
    rst_n = 0;
    #1;
    n_cmp++; if (out !== 4'b0) begin n_fail++; $display("FAIL reset_out got %b want 0000", out); end
    n_cmp++; if (blk !== 1'b0) begin n_fail++; $display("FAIL reset_blocked got %b want 0", blk); end
    n_cmp++; if (trp !== 1'b0) begin n_fail++; $display("FAIL reset_tripped got %b want 0", trp); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt); end
    rst_n = 1;
    step();
    n_cmp++; if (out !== 4'b1010) begin n_fail++; $display("FAIL reset_release_out got %b want 1010", out); end
  endtask
  task automatic test_passthrough();
    reset();
    in = 4'b1010;
    step();
    n_cmp++; if (out !== 4'b1010) begin n_fail++; $display("FAIL pass_out1 got %b want 1010", out); end
    in = 4'b0110;
    step();
    n_cmp++; if (out !== 4'b0110) begin n_fail++; $display("FAIL pass_out2 got %b want 0110", out); end
    n_cmp++; if (blk !== 1'b0) begin n_fail++; $display("FAIL pass_blocked got %b want 0", blk); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL pass_count got %0d want 0", cnt); end
  endtask
  task automatic test_trip_holdoff();
    reset();
    in = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) in = 4'b1010;
      step();
      n_cmp++; if (out !== 4'b0) begin n_fail++; $display("FAIL trip_out edge %0d got %b want 0000", i, out); end
      n_cmp++; if (blk !== 1'b1) begin n_fail++; $display("FAIL trip_blocked edge %0d got %b want 1", i, blk); end
    end
    step();
    n_cmp++; if (out !== 4'b1010) begin n_fail++; $display("FAIL trip_release_out got %b want 1010", out); end
    n_cmp++; if (blk !== 1'b0) begin n_fail++; $display("FAIL trip_release_blocked got %b want 0", blk); end
    n_cmp++; if (trp !== 1'b1) begin n_fail++; $display("FAIL trip_tripped got %b want 1", trp); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL trip_count got %0d want 1", cnt); end
  endtask
  task automatic test_retrigger();
    reset();
    in = 4'b1011;
    step();
    in = 4'b1010;
    step();
    step();
    in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      in = 4'b0100;
      n_cmp++; if (out !== 4'b0) begin n_fail++; $display("FAIL retrig_out edge %0d got %b want 0000", i, out); end
    end
    step();
    n_cmp++; if (out !== 4'b0100) begin n_fail++; $display("FAIL retrig_release_out got %b want 0100", out); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL retrig_count got %0d want 1", cnt); end
  endtask
  task automatic test_clear_saturate();
    reset();
    repeat (5) do_trip();
    n_cmp++; if (cnt !== 8'd5) begin n_fail++; $display("FAIL five_trips_count got %0d want 5", cnt); end
    n_cmp++; if (cnt_c !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d want 3", cnt_c); end
    n_cmp++; if (trp_c !== 1'b1) begin n_fail++; $display("FAIL sat_tripped got %b want 1", trp_c); end
    in = 4'b1011;
    clr = 1;
    step();
    clr = 0;
    n_cmp++; if (trp !== 1'b1) begin n_fail++; $display("FAIL clr_trip_tripped got %b want 1", trp); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL clr_trip_count got %0d want 1", cnt); end
    in = 4'b1010;
    repeat (4) step();
    clr = 1;
    step();
    clr = 0;
    n_cmp++; if (trp !== 1'b0) begin n_fail++; $display("FAIL clr_tripped got %b want 0", trp); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", cnt); end
    n_cmp++; if (out !== 4'b1010) begin n_fail++; $display("FAIL clr_out got %b want 1010", out); end
  endtask
  task automatic test_hold_zero();
    reset();
    in = 4'b1011;
    step();
    n_cmp++; if (out_h !== 4'b0) begin n_fail++; $display("FAIL h0_block_out got %b want 0000", out_h); end
    n_cmp++; if (blk_h !== 1'b1) begin n_fail++; $display("FAIL h0_block_blocked got %b want 1", blk_h); end
    in = 4'b1010;
    step();
    n_cmp++; if (out_h !== 4'b1010) begin n_fail++; $display("FAIL h0_release_out got %b want 1010", out_h); end
    n_cmp++; if (blk_h !== 1'b0) begin n_fail++; $display("FAIL h0_release_blocked got %b want 0", blk_h); end
  endtask
  task automatic test_polarity();
    reset();
    in = 4'b1111;
    step();
    n_cmp++; if (out_p !== 4'b1111) begin n_fail++; $display("FAIL pol_pass_out got %b want 1111", out_p); end
    in = 4'b1110;
    step();
    n_cmp++; if (out_p !== 4'b0) begin n_fail++; $display("FAIL pol_block_out got %b want 0000", out_p); end
    n_cmp++; if (blk_p !== 1'b1) begin n_fail++; $display("FAIL pol_block_blocked got %b want 1", blk_p); end
    n_cmp++; if (cnt_p !== 8'd1) begin n_fail++; $display("FAIL pol_count got %0d want 1", cnt_p); end
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_trip_holdoff();
    test_retrigger();
    test_clear_saturate();
    test_hold_zero();
    test_polarity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
